// File: rtl/dense_layer_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dense_layer_ctrl_pkg
// Purpose  : Shared helpers for the dense layer controller: address-width
//            derivation, FSM state encoding, memory word field offsets.
// Revision : 1.0 - initial release
// ============================================================================
package dense_layer_ctrl_pkg;

  // Ceiling log2 usable in constant expressions
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Neuron index width; a single-neuron layer still gets a one-bit address
  function automatic int addr_width(input int num_neurons);
    return (clog2(num_neurons) < 1) ? 1 : clog2(num_neurons);
  endfunction

  // Memory word layout: {bias, w_flat}, weight element 0 in the LSBs
  localparam int W_LSB = 0;

  function automatic int bias_lsb(input int num_inputs, input int w_w);
    return num_inputs * w_w;
  endfunction

  // Controller state encoding
  localparam int            ST_W       = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH   = 3'd1;
  localparam logic [ST_W-1:0] ST_RD_WAIT = 3'd2;
  localparam logic [ST_W-1:0] ST_ISSUE   = 3'd3;
  localparam logic [ST_W-1:0] ST_COLLECT = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/dense_layer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dense_layer_ctrl
// Purpose  : Sequences one fully-connected layer over a single shared serial
//            MAC neuron: per neuron fetch weights/bias, issue one operation,
//            collect the result; present the full vector via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module dense_layer_ctrl
  import dense_layer_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 8,
  parameter int X_W         = 8,
  parameter int W_W         = 8,
  parameter int B_W         = 32,
  parameter int OUT_W       = 16,
  localparam int AW         = addr_width(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  // layer input stream
  input  logic                              layer_in_valid,
  output logic                              layer_in_ready,
  input  logic [NUM_INPUTS*X_W-1:0]         layer_x_flat,
  // weight memory
  output logic                              wmem_rd_en,
  output logic [AW-1:0]                     wmem_addr,
  input  logic [NUM_INPUTS*W_W+B_W-1:0]     wmem_rd_data,
  // serial neuron
  output logic                              nrn_in_valid,
  input  logic                              nrn_in_ready,
  output logic [B_W-1:0]                    nrn_bias,
  output logic [NUM_INPUTS*X_W-1:0]         nrn_x_flat,
  output logic [NUM_INPUTS*W_W-1:0]         nrn_w_flat,
  input  logic                              nrn_out_valid,
  input  logic [OUT_W-1:0]                  nrn_out_data,
  // layer output
  output logic                              layer_out_valid,
  input  logic                              layer_out_ready,
  output logic [NUM_NEURONS*OUT_W-1:0]      layer_out_flat,
  output logic                              busy
);

  localparam int            XF_W     = NUM_INPUTS * X_W;
  localparam int            WF_W     = NUM_INPUTS * W_W;
  localparam int            BIAS_LSB = bias_lsb(NUM_INPUTS, W_W);
  localparam logic [AW-1:0] LAST_N   = AW'(NUM_NEURONS - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic [AW-1:0]   n_q, n_d;
  logic [XF_W-1:0] x_q;
  logic [WF_W-1:0] w_q;
  logic [B_W-1:0]  b_q;

  logic accept_in;     // layer input handshake this cycle
  logic collect_fire;  // neuron result arrives while we wait for it

  assign accept_in    = (state_q == ST_IDLE) && layer_in_valid;
  assign collect_fire = (state_q == ST_COLLECT) && nrn_out_valid;

  // State and neuron-index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (layer_in_valid) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_ISSUE;
      ST_ISSUE:   if (nrn_in_ready) state_d = ST_COLLECT;
      ST_COLLECT: if (nrn_out_valid) state_d = (n_q == LAST_N) ? ST_DONE : ST_FETCH;
      ST_DONE:    if (layer_out_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Neuron index: cleared on layer accept, advanced after each collected result
  always_comb begin
    n_d = n_q;
    if (accept_in) begin
      n_d = '0;
    end else if (collect_fire && (n_q != LAST_N)) begin
      n_d = n_q + AW'(1);
    end
  end

  // State-decoded control outputs; address only shown while reading
  always_comb begin
    layer_in_ready  = 1'b0;
    busy            = 1'b1;
    wmem_rd_en      = 1'b0;
    wmem_addr       = '0;
    nrn_in_valid    = 1'b0;
    layer_out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        layer_in_ready = 1'b1;
        busy           = 1'b0;
      end
      ST_FETCH: begin
        wmem_rd_en = 1'b1;
        wmem_addr  = n_q;
      end
      ST_ISSUE: nrn_in_valid    = 1'b1;
      ST_DONE:  layer_out_valid = 1'b1;
      default:  ;
    endcase
  end

  // Input vector latch: held for the whole layer, new inputs ignored while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
    end else if (accept_in) begin
      x_q <= layer_x_flat;
    end
  end

  // Weight/bias capture one cycle after the read strobe (synchronous memory)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      b_q <= '0;
    end else if (state_q == ST_RD_WAIT) begin
      w_q <= wmem_rd_data[W_LSB +: WF_W];
      b_q <= wmem_rd_data[BIAS_LSB +: B_W];
    end
  end

  // Neuron operands come straight from registers so they are stable in ISSUE
  assign nrn_x_flat = x_q;
  assign nrn_w_flat = w_q;
  assign nrn_bias   = b_q;

  // Output buffer: one slot per neuron, written only by a result in COLLECT
  generate
    for (genvar j = 0; j < NUM_NEURONS; j++) begin : g_slot
      logic [OUT_W-1:0] slot_q;

      // Capture result for neuron j; stray result pulses elsewhere are dropped
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_q <= '0;
        end else if (collect_fire && (n_q == AW'(j))) begin
          slot_q <= nrn_out_data;
        end
      end

      assign layer_out_flat[j*OUT_W +: OUT_W] = slot_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/dense_layer_ctrl.md
# dense_layer_ctrl

Sequencer that evaluates one fully-connected layer of NUM_NEURONS outputs on a single shared serial MAC neuron. Per neuron it reads a weight/bias word from an external synchronous memory, issues one neuron operation, and stores the result in an output buffer. It presents the completed vector through a valid/ready handshake. It sits between the layer input stream and the serial neuron, with a weight ROM/RAM on the side.

## Interface
- NUM_NEURONS, 4: neurons per layer (≥1)
- NUM_INPUTS, 8: elements per input vector; must match the neuron
- X_W, 8: input element width
- W_W, 8: weight width
- B_W, 32: bias width
- OUT_W, 16: neuron result width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- layer_in_valid  in  1  input vector valid
- layer_in_ready  out  1  high only in IDLE
- layer_x_flat  in  NUM_INPUTS*X_W  input vector, element 0 in LSBs
- wmem_rd_en  out  1  memory read strobe
- wmem_addr  out  AW=max(1,clog2(NUM_NEURONS))  neuron index
- wmem_rd_data  in  NUM_INPUTS*W_W+B_W  {bias, w_flat}; w element 0 in LSBs; valid exactly 1 cycle after rd_en
- nrn_in_valid  out  1  neuron request
- nrn_in_ready  in  1  neuron can accept
- nrn_bias  out  B_W  bias for current neuron
- nrn_x_flat  out  NUM_INPUTS*X_W  latched layer input
- nrn_w_flat  out  NUM_INPUTS*W_W  weights for current neuron
- nrn_out_valid  in  1  one-cycle result pulse
- nrn_out_data  in  OUT_W  neuron result
- layer_out_valid  out  1  result vector valid
- layer_out_ready  in  1  consumer accepts
- layer_out_flat  out  NUM_NEURONS*OUT_W  neuron j in bits [j*OUT_W +: OUT_W]
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, FETCH, RD_WAIT, ISSUE, COLLECT, DONE; counter n (AW bits) = current neuron.
- IDLE: layer_in_valid & layer_in_ready → latch layer_x_flat into x_reg, n←0, go FETCH.
- FETCH: wmem_rd_en=1, wmem_addr=n, go RD_WAIT (unconditional).
- RD_WAIT: capture wmem_rd_data into w_reg/b_reg at end of cycle, go ISSUE.
- ISSUE: nrn_in_valid=1; nrn_bias/nrn_w_flat/nrn_x_flat are driven from registers and stay stable until nrn_in_valid & nrn_in_ready, then go COLLECT.
- COLLECT: wait for nrn_out_valid (no timeout), then write nrn_out_data into buffer slot n. If n==NUM_NEURONS-1 go DONE, else n←n+1 and go FETCH.
- DONE: layer_out_valid=1 and layer_out_flat held stable; on layer_out_ready go IDLE. layer_in_ready stays 0 until the cycle after.
- nrn_out_valid outside COLLECT is ignored and leaves the buffer unchanged.
- layer_in_valid outside IDLE is ignored; no input queuing.
- No arithmetic in this block; results pass through bit-exact.
- Reset (any time, including mid-layer): state IDLE, all registers cleared. The neuron shares rst_n, so no stale result survives.

## Timing
- Reset values: layer_in_ready=1 (combinational from IDLE). All other outputs are 0: wmem_rd_en, wmem_addr, nrn_in_valid, nrn_bias, nrn_x_flat, nrn_w_flat, layer_out_valid, layer_out_flat, busy.
- Per neuron with an idle neuron: FETCH 1 + RD_WAIT 1 + ISSUE 1 + neuron compute NUM_INPUTS + COLLECT 1 = NUM_INPUTS+4 cycles.
- layer_out_valid rises NUM_NEURONS*(NUM_INPUTS+4)+1 edges after the accepting layer edge (49 at defaults).
- Each cycle nrn_in_ready is low in ISSUE adds one cycle.
- layer_out_valid is a level, not a pulse. It stays high until the ready edge and drops on the following cycle.
- Back-to-back layers: minimum one IDLE cycle between the DONE handshake and the next accept.

## Structure
- Shared package: clog2 function, state encoding localparams, AW derivation, memory word field offsets (W_LSB=0, BIAS_LSB=NUM_INPUTS*W_W).
- No sub-module. The neuron is instantiated beside this block by the layer top, so the controller can be verified against a stub neuron.

## Test plan
- Defaults, real neuron with ReLU and all FRAC=8 scale; x all 0x10; neuron j weights all 0x10, bias j*256 → layer_out_flat = {2816,2560,2304,2048} (slot 0 = 2048); layer_out_valid 49 edges after accept.
- Weights all 0xF0, bias 0 → every slot 0 (ReLU). x=w=0x7F everywhere → every slot 0x7FFF (saturation).
- Stub neuron holds nrn_in_ready low 3 cycles in ISSUE → nrn_in_valid and data stable, accept on 4th cycle, total latency +3.
- layer_out_ready low for 10 cycles in DONE → layer_out_flat unchanged, layer_in_ready=0, new layer_in_valid ignored; then handshake → IDLE next cycle.
- Stub pulses nrn_out_valid during FETCH → buffer unchanged; wmem_addr sequence 0,1,2,3 with one rd_en per neuron.
- rst_n low during neuron 2 compute → all outputs at reset values immediately; subsequent layer completes correctly with fresh results.
